// File: rtl/if_fetch_align.sv
// if_fetch_align: RV32IC fetch front end that realigns compressed and straddling instructions from a 1-cycle-latency imem.
module if_fetch_align #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic                  valid_o,
  output logic [31:0]           instr_o,
  output logic [31:0]           pc_o,
  output logic                  compressed_o
);
  typedef enum logic {FILL, RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [15:0] r_buf, w_buf_nxt;
  logic        r_bufv, w_bufv_nxt;
  logic [15:0] w_half;
  logic [31:0] w_full;
  logic        w_cmp, w_cold, w_valid, w_acc;
  // With r_bufv set, r_buf is the upper half of pc's word and imem_dout already holds the next word.
  assign w_half  = r_bufv ? r_buf : (r_pc[1] ? imem_dout[31:16] : imem_dout[15:0]);
  assign w_full  = r_bufv ? {imem_dout[15:0], r_buf} : imem_dout;
  assign w_cmp   = w_half[1:0] != 2'b11;
  assign w_cold  = ~r_bufv & r_pc[1] & ~w_cmp;
  assign w_valid = (r_state == RUN) & ~w_cold;
  assign w_acc   = w_valid & ~stall_i & ~redirect_i;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_bufv_nxt  = r_bufv;
    if (redirect_i) begin
      w_state_nxt = FILL;
      w_pc_nxt    = redirect_pc_i & ~32'h1;
      w_buf_nxt   = '0;
      w_bufv_nxt  = 1'b0;
    end else if (r_state == FILL) begin
      w_state_nxt = RUN;
    end else if (w_cold) begin
      w_buf_nxt  = imem_dout[31:16];
      w_bufv_nxt = 1'b1;
    end else if (w_acc) begin
      // An odd-halfword successor always starts in the upper half of the current word.
      w_pc_nxt   = r_pc + (w_cmp ? 32'd2 : 32'd4);
      w_buf_nxt  = imem_dout[31:16];
      w_bufv_nxt = r_pc[1] ^ w_cmp;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
      r_bufv  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
      r_bufv  <= w_bufv_nxt;
    end
  end
  assign imem_addr    = !rst_n ? RESET_PC[ADDR_WIDTH+1:2]
                               : w_pc_nxt[ADDR_WIDTH+1:2] + ADDR_WIDTH'(w_bufv_nxt);
  assign valid_o      = w_valid;
  assign compressed_o = w_valid & w_cmp;
  assign instr_o      = !w_valid ? 32'h0 : (w_cmp ? {16'h0, w_half} : w_full);
  assign pc_o         = r_pc;
endmodule

// File: tb/tb_if_fetch_align.sv
// tb_if_fetch_align: directed per-cycle vectors against a behavioural imem, plus reset corner sequences.
module tb_if_fetch_align;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] imem_addr;
  logic [31:0] imem_dout;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o, compressed_o;
  logic [31:0] instr_o, pc_o;
  logic [31:0] mem [2048];

  if_fetch_align dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .compressed_o(compressed_o)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) imem_dout <= mem[imem_addr];

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic [10:0] addr;
  } vec_t;
  vec_t vq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc, input logic v,
                     input logic [31:0] instr, input logic [31:0] pc, input logic c, input logic [10:0] addr);
    vec_t e;
    e.st = st; e.rd = rd; e.rpc = rpc; e.v = v; e.instr = instr; e.pc = pc; e.c = c; e.addr = addr;
    vq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic c, input logic [10:0] addr);
    chk({nm, "_valid"}, {31'b0, valid_o}, {31'b0, v});
    chk({nm, "_instr"}, instr_o, instr);
    chk({nm, "_pc"}, pc_o, pc);
    chk({nm, "_cmp"}, {31'b0, compressed_o}, {31'b0, c});
    chk({nm, "_addr"}, {21'b0, imem_addr}, {21'b0, addr});
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0000_0013;
    mem[0]     = 32'h0050_0093;
    mem[1]     = 32'h00A0_0113;
    mem[16]    = 32'h4509_4501;
    mem[32]    = 32'h0093_4501;
    mem[33]    = 32'h1111_0050;
    mem[64]    = 32'h0113_0001;
    mem[65]    = 32'h2222_00A0;
    mem[2047]  = 32'h0093_AAAA;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

    // st rd rpc            v  instr          pc             c  addr
    add(0, 0, 32'h0,     0, 32'h0,          32'h0,        0, 11'h000); // fill after reset
    add(0, 0, 32'h0,     1, 32'h0050_0093,  32'h0,        0, 11'h001);
    add(1, 0, 32'h0,     1, 32'h00A0_0113,  32'h4,        0, 11'h001); // stall x3
    add(1, 0, 32'h0,     1, 32'h00A0_0113,  32'h4,        0, 11'h001);
    add(1, 0, 32'h0,     1, 32'h00A0_0113,  32'h4,        0, 11'h001);
    add(0, 0, 32'h0,     1, 32'h00A0_0113,  32'h4,        0, 11'h002);
    add(0, 0, 32'h0,     1, 32'h0000_0013,  32'h8,        0, 11'h003);
    add(0, 1, 32'h40,    1, 32'h0000_0013,  32'hC,        0, 11'h010); // redirect to pair of c.li
    add(0, 0, 32'h0,     0, 32'h0,          32'h40,       0, 11'h010);
    add(0, 0, 32'h0,     1, 32'h0000_4501,  32'h40,       1, 11'h011);
    add(0, 0, 32'h0,     1, 32'h0000_4509,  32'h42,       1, 11'h011);
    add(0, 1, 32'h80,    1, 32'h0000_0013,  32'h44,       0, 11'h020); // redirect to warm straddle
    add(0, 0, 32'h0,     0, 32'h0,          32'h80,       0, 11'h020);
    add(0, 0, 32'h0,     1, 32'h0000_4501,  32'h80,       1, 11'h021);
    add(0, 0, 32'h0,     1, 32'h0050_0093,  32'h82,       0, 11'h022);
    add(0, 0, 32'h0,     1, 32'h0000_1111,  32'h86,       1, 11'h022);
    add(1, 1, 32'h103,   1, 32'h0000_0013,  32'h88,       0, 11'h040); // redirect wins over stall
    add(1, 0, 32'h0,     0, 32'h0,          32'h102,      0, 11'h040);
    add(1, 0, 32'h0,     0, 32'h0,          32'h102,      0, 11'h041); // cold straddle bubble
    add(0, 0, 32'h0,     1, 32'h00A0_0113,  32'h102,      0, 11'h042);
    add(0, 1, 32'h1FFE,  1, 32'h0000_2222,  32'h106,      1, 11'h7FF); // redirect to wrap straddle
    add(0, 0, 32'h0,     0, 32'h0,          32'h1FFE,     0, 11'h7FF);
    add(0, 0, 32'h0,     0, 32'h0,          32'h1FFE,     0, 11'h000);
    add(0, 0, 32'h0,     1, 32'h0093_0093,  32'h1FFE,     0, 11'h001);
    add(0, 0, 32'h0,     1, 32'h0000_0050,  32'h2002,     1, 11'h001);
    add(0, 1, 32'h102,   1, 32'h00A0_0113,  32'h2004,     0, 11'h040);
    add(0, 0, 32'h0,     0, 32'h0,          32'h102,      0, 11'h040);
    add(0, 0, 32'h0,     0, 32'h0,          32'h102,      0, 11'h041);

    repeat (3) @(posedge clk);
    #1 chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 11'h000);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vq[i]) begin
      stall_i = vq[i].st; redirect_i = vq[i].rd; redirect_pc_i = vq[i].rpc;
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vq[i].v, vq[i].instr, vq[i].pc, vq[i].c, vq[i].addr);
      @(posedge clk); #1;
    end

    // Straddle half-consumed in the buffer, then async reset mid-cycle.
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    chk("pre_rst_instr", instr_o, 32'h00A0_0113);
    #1 rst_n = 1'b0;
    #1 chk_all("midrst", 1'b0, 32'h0, 32'h0, 1'b0, 11'h000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all("post_rst_fill", 1'b0, 32'h0, 32'h0, 1'b0, 11'h000);
    @(posedge clk); @(negedge clk);
    chk_all("post_rst_first", 1'b1, 32'h0050_0093, 32'h0, 1'b0, 11'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
